// File: rtl/instruction_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instruction_sequencer
// Description : Multi-byte instruction fetch / decode / execute sequencer.
//               Fetches an opcode and up to two operand bytes over a simple
//               request/acknowledge memory port, then runs a counted execute
//               phase followed by a one-cycle writeback strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'hF000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            instr_len,
  input  logic [2:0]            exec_steps,
  input  logic                  is_halt,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] temp_1_out,
  output logic [DATA_WIDTH-1:0] temp_2_out,
  output logic [ADDR_WIDTH-1:0] counter_out,
  output logic [2:0]            microstep,
  output logic                  exec_valid,
  output logic                  latch_en,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] c_PC_INC = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_CHK_MORE = 3'd2,
    S_OPERAND  = 3'd3,
    S_EXECUTE  = 3'd4,
    S_LATCH    = 3'd5,
    S_HALT     = 3'd6
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_temp1;
  logic [DATA_WIDTH-1:0] r_temp2;
  logic                  r_req;
  logic [1:0]            r_nbytes;   // bytes of the current instruction already fetched
  logic [2:0]            r_step;
  logic                  r_exec_valid;
  logic                  r_latch_en;
  logic                  r_halted;

  logic [1:0]            w_len;
  logic                  w_last_step;

  // A zero length from the decoder still means the opcode byte itself
  assign w_len       = (instr_len == 2'd0) ? 2'd1 : instr_len;
  // Compared one bit wider so a step count of 0 can never wrap into a match
  assign w_last_step = ({1'b0, r_step} + 4'd1) >= {1'b0, exec_steps};

  // Sequencer state machine with all outputs held in registers.
  // FETCH is entered from LATCH with the request already raised (zero-wait
  // opcode fetch); OPERAND and the first fetch after reset spend one setup
  // cycle before raising the request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_VECTOR;
      r_opcode     <= '0;
      r_temp1      <= '0;
      r_temp2      <= '0;
      r_req        <= 1'b0;
      r_nbytes     <= 2'd0;
      r_step       <= 3'd0;
      r_exec_valid <= 1'b0;
      r_latch_en   <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (mem_rd_ack) begin
            r_opcode <= mem_rdata;
            r_pc     <= r_pc + c_PC_INC;
            r_req    <= 1'b0;
            r_nbytes <= 2'd1;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_CHK_MORE;
        end
        S_CHK_MORE: begin
          if (r_nbytes < w_len) begin
            r_state <= S_OPERAND;
          end else if (is_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (exec_steps == 3'd0) begin
            r_latch_en <= 1'b1;
            r_state    <= S_LATCH;
          end else begin
            r_exec_valid <= 1'b1;
            r_step       <= 3'd0;
            r_state      <= S_EXECUTE;
          end
        end
        S_OPERAND: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (mem_rd_ack) begin
            if (r_nbytes == 2'd1) begin
              r_temp1 <= mem_rdata;
            end else begin
              r_temp2 <= mem_rdata;
            end
            r_nbytes <= r_nbytes + 2'd1;
            r_pc     <= r_pc + c_PC_INC;
            r_req    <= 1'b0;
            r_state  <= S_CHK_MORE;
          end
        end
        S_EXECUTE: begin
          if (pc_load) begin
            r_pc <= pc_load_value;
          end
          if (w_last_step) begin
            r_exec_valid <= 1'b0;
            r_step       <= 3'd0;
            r_latch_en   <= 1'b1;
            r_state      <= S_LATCH;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        S_LATCH: begin
          r_latch_en <= 1'b0;
          r_req      <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_req  = r_req;
  assign mem_addr    = r_pc;
  assign opcode      = r_opcode;
  assign temp_1_out  = r_temp1;
  assign temp_2_out  = r_temp2;
  assign counter_out = r_pc;
  assign microstep   = r_step;
  assign exec_valid  = r_exec_valid;
  assign latch_en    = r_latch_en;
  assign halted      = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_instruction_sequencer
// Description : Scoreboard bench for instruction_sequencer. A program-level
//               reference model walks memory and queues one record per
//               instruction; a monitor pops and compares on latch_en/halted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd_req;
  logic [15:0] mem_addr;
  logic        mem_rd_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [1:0]  instr_len;
  logic [2:0]  exec_steps;
  logic        is_halt;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic [7:0]  opcode, temp_1_out, temp_2_out;
  logic [15:0] counter_out;
  logic [2:0]  microstep;
  logic        exec_valid, latch_en, halted;

  instruction_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .RESET_VECTOR(16'hF000)) dut (
    .clk(clk), .reset(reset),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
    .instr_len(instr_len), .exec_steps(exec_steps), .is_halt(is_halt),
    .pc_load(pc_load), .pc_load_value(pc_load_value),
    .opcode(opcode), .temp_1_out(temp_1_out), .temp_2_out(temp_2_out),
    .counter_out(counter_out), .microstep(microstep), .exec_valid(exec_valid),
    .latch_en(latch_en), .halted(halted)
  );

  always #5 clk = ~clk;

  // Toy instruction set decoded from the opcode byte:
  // [1:0] length, [4:2] execute steps, [7:5]==101 jump to {byte3,byte2}, 3C = HLT
  localparam logic [7:0] HLT = 8'h3C;
  assign instr_len  = opcode[1:0];
  assign exec_steps = opcode[4:2];
  assign is_halt    = (opcode == HLT);

  function automatic bit is_jump(input logic [7:0] op);
    return op[7:5] == 3'b101;
  endfunction

  typedef struct {
    bit          halt;
    logic [7:0]  op, t1, t2;
    logic [15:0] pc;
    int          steps;
    int          cycles;
  } exp_t;

  logic [7:0]  mem [0:65535];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  bit          zero_wait = 1'b1;
  bit          noise = 1'b0;
  logic [15:0] m_pc;
  logic [7:0]  m_t1, m_t2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Program-level reference: walk the instruction stream in memory
  task automatic build(input int n);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      logic [7:0] op;
      int len, steps;
      op = mem[m_pc]; m_pc = m_pc + 16'd1;
      len = (op[1:0] == 2'd0) ? 1 : int'(op[1:0]);
      if (len >= 2) begin m_t1 = mem[m_pc]; m_pc = m_pc + 16'd1; end
      if (len == 3) begin m_t2 = mem[m_pc]; m_pc = m_pc + 16'd1; end
      e.op = op; e.t1 = m_t1; e.t2 = m_t2;
      if (op == HLT) begin
        e.halt = 1'b1; e.pc = m_pc; e.steps = 0; e.cycles = -1;
        sb.push_back(e);
        return;
      end
      steps = int'(op[4:2]);
      if (is_jump(op) && steps > 0) m_pc = {m_t2, m_t1};
      e.halt = 1'b0; e.pc = m_pc; e.steps = steps;
      e.cycles = zero_wait ? (1 + 1 + len + 2 * (len - 1) + steps + 1) : -1;
      sb.push_back(e);
    end
  endtask

  // Memory responder: ack may come in the request's first cycle
  int  wcnt = 0;
  bit  pending = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!reset || !mem_rd_req) begin
      pending    = 1'b0;
      mem_rd_ack = noise ? 1'($urandom % 2) : 1'b0;
      mem_rdata  = 8'($urandom);
    end else begin
      if (!pending) begin
        pending = 1'b1;
        wcnt    = zero_wait ? 0 : int'($urandom % 4);
      end
      if (wcnt == 0) begin
        mem_rd_ack = 1'b1;
        mem_rdata  = mem[mem_addr];
        pending    = 1'b0;
      end else begin
        mem_rd_ack = 1'b0;
        mem_rdata  = 8'($urandom);
        wcnt--;
      end
    end
  end

  // Jump driver: pc_load at execute step 0 of jump opcodes, random junk elsewhere outside EXECUTE
  always @(posedge clk) begin
    #1;
    if (exec_valid) begin
      pc_load       = (microstep == 3'd0) && is_jump(opcode);
      pc_load_value = {temp_2_out, temp_1_out};
    end else begin
      pc_load       = 1'($urandom % 2);
      pc_load_value = 16'($urandom);
    end
  end

  // Monitor / scoreboard
  int   cyc = 0, ecount = 0;
  bit   prev_req = 0, prev_ack = 0, prev_latch = 0, prev_halted = 0;
  logic [15:0] prev_addr = 16'h0;
  exp_t e_got;
  always @(negedge clk) begin
    if (!reset) begin
      cyc = 0; ecount = 0;
      prev_req = 0; prev_ack = 0; prev_latch = 0; prev_halted = 0;
    end else begin
      cyc++;
      if (exec_valid) begin
        chk("microstep_seq", 32'(microstep), 32'(ecount));
        ecount++;
      end else begin
        chk("microstep_idle", 32'(microstep), 32'd0);
      end
      if (exec_valid || latch_en || halted) chk("req_quiet", 32'(mem_rd_req), 32'd0);
      if (prev_req && !prev_ack && mem_rd_req) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
      if (latch_en) begin
        chk("latch_single", 32'(prev_latch), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_latch", 32'd1, 32'd0);
        end else begin
          e_got = sb.pop_front();
          chk("kind_latch", 32'(e_got.halt), 32'd0);
          chk("opcode", 32'(opcode), 32'(e_got.op));
          chk("temp_1", 32'(temp_1_out), 32'(e_got.t1));
          chk("temp_2", 32'(temp_2_out), 32'(e_got.t2));
          chk("pc_next", 32'(counter_out), 32'(e_got.pc));
          chk("exec_cycles", 32'(ecount), 32'(e_got.steps));
          if (e_got.cycles >= 0) chk("instr_cycles", 32'(cyc), 32'(e_got.cycles));
        end
        ecount = 0; cyc = 0;
      end
      if (halted && !prev_halted) begin
        if (sb.size() == 0) begin
          chk("unexpected_halt", 32'd1, 32'd0);
        end else begin
          e_got = sb.pop_front();
          chk("kind_halt", 32'(e_got.halt), 32'd1);
          chk("halt_opcode", 32'(opcode), 32'(e_got.op));
          chk("halt_pc", 32'(counter_out), 32'(e_got.pc));
        end
      end
      prev_req = mem_rd_req; prev_ack = mem_rd_ack; prev_addr = mem_addr;
      prev_latch = latch_en; prev_halted = halted;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc"},     32'(counter_out), 32'hF000);
    chk({tag, "_opcode"}, 32'(opcode), 32'd0);
    chk({tag, "_t1"},     32'(temp_1_out), 32'd0);
    chk({tag, "_t2"},     32'(temp_2_out), 32'd0);
    chk({tag, "_ustep"},  32'(microstep), 32'd0);
    chk({tag, "_req"},    32'(mem_rd_req), 32'd0);
    chk({tag, "_exv"},    32'(exec_valid), 32'd0);
    chk({tag, "_latch"},  32'(latch_en), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  task automatic enter_reset();
    @(negedge clk); #2 reset = 1'b0;
    sb.delete();
    m_pc = 16'hF000; m_t1 = 8'h00; m_t2 = 8'h00;
  endtask

  // Release mid low-phase; the request must rise only after the first active edge
  task automatic leave_reset();
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("req_before_edge", 32'(mem_rd_req), 32'd0);
    @(negedge clk);
    chk("req_first_cycle", 32'(mem_rd_req), 32'd1);
    chk("req_first_addr", 32'(mem_addr), 32'hF000);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk); n++;
    end
    chk({tag, "_drain_timeout"}, 32'(sb.size() != 0), 32'd0);
  endtask

  task automatic hold_halt(input string tag);
    bit bad;
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (mem_rd_req || !halted) bad = 1'b1;
    end
    chk({tag, "_halt_hold"}, 32'(bad), 32'd0);
  endtask

  task automatic fill_random();
    for (int a = 0; a < 65536; a++) begin
      logic [7:0] b;
      b = 8'($urandom);
      mem[a] = (b == HLT) ? 8'h3D : b;
    end
  endtask

  initial begin
    fill_random();
    repeat (2) @(negedge clk);
    check_reset_outputs("por");

    // Random programs, zero-wait memory
    zero_wait = 1'b1; noise = 1'b0;
    enter_reset(); build(60); leave_reset(); drain("zw");

    // Random programs, random wait states and stray acks
    zero_wait = 1'b0; noise = 1'b1;
    enter_reset(); build(60); leave_reset(); drain("ws");

    // Asynchronous reset in the middle of EXECUTE
    zero_wait = 1'b1; noise = 1'b1;
    enter_reset(); build(200); leave_reset();
    begin
      int n;
      n = 0;
      while (!exec_valid && n < 2000) begin @(negedge clk); n++; end
      chk("exec_seen", 32'(exec_valid), 32'd1);
      #2 reset = 1'b0;
      #1 check_reset_outputs("midexec");
      sb.delete();
    end

    // Directed: 2-byte/0-step, 1-byte/2-step, jump to F010, HLT there
    zero_wait = 1'b1; noise = 1'b0;
    enter_reset();
    mem[16'hF000] = 8'h02; mem[16'hF001] = 8'h04;
    mem[16'hF002] = 8'h09;
    mem[16'hF003] = 8'hA7; mem[16'hF004] = 8'h10; mem[16'hF005] = 8'hF0;
    mem[16'hF010] = HLT;
    build(10); leave_reset(); drain("dirA"); hold_halt("dirA");
    chk("dirA_halt_pc", 32'(counter_out), 32'hF011);

    // Directed: jump to FFFF, 3-byte instruction wraps, HLT (length 0) at 0002
    enter_reset();
    mem[16'hF000] = 8'hA7; mem[16'hF001] = 8'hFF; mem[16'hF002] = 8'hFF;
    mem[16'hFFFF] = 8'h07; mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
    mem[16'h0002] = HLT;
    build(10); leave_reset(); drain("wrap"); hold_halt("wrap");
    chk("wrap_halt_pc", 32'(counter_out), 32'h0003);
    chk("wrap_t1", 32'(temp_1_out), 32'h11);
    chk("wrap_t2", 32'(temp_2_out), 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
